tmr_addsub_pipe: RTL and testbench
==================================

# tmr_addsub_pipe

Pipelined, parametrised successor to the combinational 3-bit TMR adder. It performs WIDTH-bit add, subtract or reverse-subtract on three replica adders with majority voting. It checks operand parity and control one-hotness, and tracks per-replica health with leaky mismatch counters. A persistently faulty replica is retired, which degrades the block from TMR to DMR compare mode. It sits in the datapath as the checked arithmetic unit, and reports errors on a two-rail pair.

## Interface
- WIDTH, 3: operand/result width (≥2)
- CNT_W, 3: per-replica mismatch counter width
- FAIL_THRESH, 4: counter value at which a replica is retired (1 ≤ FAIL_THRESH ≤ 2^CNT_W−1)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operands valid this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- par  in  1  parity bit; XOR of a, b, par must be 1 (odd parity)
- ctl  in  3  one-hot op: ctl[0] ADD (a+b), ctl[1] SUB (a+~b+1), ctl[2] RSUB (~a+b+1)
- inj  in  3  fault injection; inj[i] flips bit 0 of replica i's sum
- clr_fail  in  1  clear fail_mask and all counters
- out_valid  out  1  result valid
- sum  out  WIDTH  voted result
- cout  out  1  voted carry-out
- err0, err1  out  1 each  two-rail error code: 0/1 = no error; 0/0 = detected error
- mode  out  1  0 = TMR, 1 = DMR
- fail_mask  out  3  retired replicas (sticky)

## Operation
- Replica inputs: ai = a ^ {WIDTH{ctl[2]}}; bi = b ^ {WIDTH{ctl[1]}}; cin = ~ctl[0].
- in_err = (XOR of a, b, par == 0) OR (ctl not exactly one-hot).
- in_err result: sum=0, cout=0, err=0/0. Counters and mask are unchanged.
- TMR mode (fail_mask==0): result is the majority of the replica {cout,sum} words.
  - Exactly one replica disagrees: it is the minority. Its counter increments, saturating at 2^CNT_W−1. Each agreeing replica's counter decrements if nonzero. err=0/1.
  - All three replicas differ: output replica 0, err=0/0, counters unchanged.
  - All agree: every nonzero counter decrements.
- Retirement: when a counter reaches FAIL_THRESH, that replica's fail_mask bit sets on the same edge, and mode becomes DMR.
  - Only one minority exists per cycle, so at most one bit of fail_mask is ever set.
- DMR mode: compare the two live replicas and output the lower-index one.
  - Mismatch: err=0/0.
  - Counters are frozen in DMR.
- inj on a retired replica has no observable effect.
- clr_fail: at the next edge, fail_mask=0 and all counters=0. This wins over a same-edge increment or retirement.
- sum, cout, err0, err1 hold their last values while out_valid=0.

## Timing
- Stage 1 registers a, b, par, ctl, inj and in_valid at edge N.
- Stage 2 computes replicas, checks and vote combinationally from the stage 1 registers. At edge N+1 it registers sum, cout, err pair and out_valid, and updates counters, fail_mask and mode.
- Latency: in_valid at edge N gives out_valid high after edge N+1. Full throughput, no backpressure.
- A retirement at edge N+1 governs the vote at edge N+2.
- Counters update only on cycles where the stage 1 valid is high.
- Reset values: out_valid=0, sum=0, cout=0, err0=0, err1=1, mode=0, fail_mask=0, counters=0, pipeline valids=0.
- Reset asserted mid-operation drops in-flight data. No out_valid follows for it.

## Structure
- Shared package tmr_pkg holds:
  - mode encodings MODE_TMR and MODE_DMR
  - ctl bit indices CTL_ADD, CTL_SUB, CTL_RSUB
  - two-rail constants ERR_OK (2'b01) and ERR_DET (2'b00)
- Sub-module rca_w (parameter WIDTH): ripple-carry adder with ports a, b, cin, sum and cout. Instantiate it three times.
- Voter, checks and counters live in the top.

## Test plan
- WIDTH=4, FAIL_THRESH=3 throughout.
- ADD a=5, b=6, par=1, ctl=001 → after edge N+1: out_valid=1, sum=11, cout=0, err=0/1, mode=0.
- SUB a=3, b=5, par=1, ctl=010 → sum=14, cout=0, err=0/1.
- Case 1 with par=0, or ctl=011 → sum=0, cout=0, err=0/0, counters unchanged.
- inj=010 on 3 consecutive valid ADDs of case 1 → each sum=11, err=0/1. After the third, fail_mask=010 and mode=1.
  - Next op with inj=001 → sum=10, err=0/0.
  - clr_fail → fail_mask=000, mode=0.
- Leaky counter: inj=100 ×2, clean ×2, inj=100 ×2 → fail_mask stays 000 (counter 2→0→2).
- Back-to-back: 4 valid ops on consecutive cycles yield 4 consecutive out_valid. rst asserted with an op in stage 1 → out_valid stays 0 and err resets to 0/1.

Source files
------------

// File: rtl/tmr_pkg.sv
// Shared encodings for the TMR add/sub pipeline.
package tmr_pkg;

  localparam logic MODE_TMR = 1'b0;
  localparam logic MODE_DMR = 1'b1;

  localparam int CTL_ADD  = 0;
  localparam int CTL_SUB  = 1;
  localparam int CTL_RSUB = 2;

  // Two-rail error pair {err0, err1}
  localparam logic [1:0] ERR_OK  = 2'b01;
  localparam logic [1:0] ERR_DET = 2'b00;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/rca_w.sv
// Parametrised ripple-carry adder, one instance per replica.
module rca_w #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] c;

  // Carry ripples from bit 0 upward
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[WIDTH];
  end

endmodule

// File: rtl/tmr_addsub_pipe.sv
// Two-stage checked add/sub unit: three voted replicas, input checks,
// leaky per-replica mismatch counters and TMR->DMR degradation.
module tmr_addsub_pipe
  import tmr_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int CNT_W       = 3,
  parameter int FAIL_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             par,
  input  logic [2:0]       ctl,
  input  logic [2:0]       inj,
  input  logic             clr_fail,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             err0,
  output logic             err1,
  output logic             mode,
  output logic [2:0]       fail_mask
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(FAIL_THRESH);

  // stage 1 registers
  logic [WIDTH-1:0] a_d, a_q, b_d, b_q;
  logic             par_d, par_q, vld1_d, vld1_q;
  logic [2:0]       ctl_d, ctl_q, inj_d, inj_q;

  // stage 2 / status registers
  logic [WIDTH-1:0]            sum_d, sum_q;
  logic                        cout_d, cout_q, out_valid_d, out_valid_q;
  logic [1:0]                  err_d, err_q;
  logic                        mode_d, mode_q;
  logic [2:0]                  mask_d, mask_q;
  logic [2:0][CNT_W-1:0]       cnt_d, cnt_q;

  // replica datapath
  logic [WIDTH-1:0]            ai, bi;
  logic                        cin;
  logic [2:0][WIDTH-1:0]       rs;
  logic [2:0]                  rc;
  logic [2:0][WIDTH:0]         rw;

  // vote results
  logic [WIDTH:0]              word;
  logic [1:0]                  vote_err;
  logic                        has_min, all_agree, in_err;
  logic [1:0]                  min_idx;

  // Stage 1 captures operands every cycle; vld1 qualifies them
  always_comb begin
    a_d    = a;
    b_d    = b;
    par_d  = par;
    ctl_d  = ctl;
    inj_d  = inj;
    vld1_d = in_valid;
  end

  assign ai  = a_q ^ {WIDTH{ctl_q[CTL_RSUB]}};
  assign bi  = b_q ^ {WIDTH{ctl_q[CTL_SUB]}};
  assign cin = ~ctl_q[CTL_ADD];

  for (genvar g = 0; g < 3; g++) begin : g_rep
    rca_w #(.WIDTH(WIDTH)) u_rca (
      .a    (ai),
      .b    (bi),
      .cin  (cin),
      .sum  (rs[g]),
      .cout (rc[g])
    );
    // injection only disturbs bit 0 of the sum, never the carry
    assign rw[g] = {rc[g], rs[g] ^ {{(WIDTH-1){1'b0}}, inj_q[g]}};
  end

  // Majority vote in TMR, lower-index pairwise compare in DMR
  always_comb begin
    word      = rw[0];
    vote_err  = ERR_OK;
    has_min   = 1'b0;
    all_agree = 1'b0;
    min_idx   = 2'd0;
    in_err    = ~(^{a_q, b_q, par_q}) | ~is_onehot3(ctl_q);
    if (mask_q == 3'b000) begin
      if ((rw[0] == rw[1]) && (rw[0] == rw[2])) begin
        all_agree = 1'b1;
      end else if (rw[0] == rw[1]) begin
        has_min = 1'b1;
        min_idx = 2'd2;
      end else if (rw[0] == rw[2]) begin
        has_min = 1'b1;
        min_idx = 2'd1;
      end else if (rw[1] == rw[2]) begin
        word    = rw[1];
        has_min = 1'b1;
        min_idx = 2'd0;
      end else begin
        vote_err = ERR_DET;
      end
    end else if (mask_q[0]) begin
      word = rw[1];
      if (rw[1] != rw[2]) vote_err = ERR_DET;
    end else begin
      word = rw[0];
      if (rw[0] != (mask_q[1] ? rw[2] : rw[1])) vote_err = ERR_DET;
    end
  end

  // Result, counter and retirement next-state; clr_fail overrides all health updates
  always_comb begin
    out_valid_d = vld1_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    if (vld1_q) begin
      if (in_err) begin
        sum_d  = '0;
        cout_d = 1'b0;
        err_d  = ERR_DET;
      end else begin
        {cout_d, sum_d} = word;
        err_d           = vote_err;
        if (has_min || all_agree) begin
          for (int i = 0; i < 3; i++) begin
            if (has_min && (2'(i) == min_idx)) begin
              if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
              if (cnt_d[i] == THRESH) mask_d[i] = 1'b1;
            end else if (cnt_q[i] != '0) begin
              cnt_d[i] = cnt_q[i] - 1'b1;
            end
          end
        end
      end
    end
    if (clr_fail) begin
      mask_d = '0;
      cnt_d  = '0;
    end
    mode_d = (mask_d != 3'b000) ? MODE_DMR : MODE_TMR;
  end

  // All pipeline and status state, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      par_q       <= 1'b0;
      ctl_q       <= '0;
      inj_q       <= '0;
      vld1_q      <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      err_q       <= ERR_OK;
      mode_q      <= MODE_TMR;
      mask_q      <= '0;
      cnt_q       <= '0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      par_q       <= par_d;
      ctl_q       <= ctl_d;
      inj_q       <= inj_d;
      vld1_q      <= vld1_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      err_q       <= err_d;
      mode_q      <= mode_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign err0      = err_q[1];
  assign err1      = err_q[0];
  assign mode      = mode_q;
  assign fail_mask = mask_q;

endmodule

// File: tb/tb_tmr_addsub_pipe.sv
// Directed bench for tmr_addsub_pipe at WIDTH=4, FAIL_THRESH=3.
module tb_tmr_addsub_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a, b;
  logic       par;
  logic [2:0] ctl, inj;
  logic       clr_fail;
  logic       out_valid;
  logic [3:0] sum;
  logic       cout, err0, err1, mode;
  logic [2:0] fail_mask;

  int n_cmp  = 0;
  int n_fail = 0;

  tmr_addsub_pipe #(.WIDTH(4), .CNT_W(3), .FAIL_THRESH(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .par       (par),
    .ctl       (ctl),
    .inj       (inj),
    .clr_fail  (clr_fail),
    .out_valid (out_valid),
    .sum       (sum),
    .cout      (cout),
    .err0      (err0),
    .err1      (err1),
    .mode      (mode),
    .fail_mask (fail_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // full result check: out_valid, sum, cout, {err0,err1}
  task automatic chk_res(input string tag, input logic [3:0] s, input logic c, input logic [1:0] e);
    chk({tag, ".valid"}, 8'(out_valid), 8'd1);
    chk({tag, ".sum"},   8'(sum), 8'(s));
    chk({tag, ".cout"},  8'(cout), 8'(c));
    chk({tag, ".err"},   8'({err0, err1}), 8'(e));
  endtask

  task automatic drive(input logic [3:0] av, input logic [3:0] bv, input logic p,
                       input logic [2:0] c, input logic [2:0] ij);
    a = av; b = bv; par = p; ctl = c; inj = ij; in_valid = 1'b1;
  endtask

  // one op: capture at edge N, result visible #1 after edge N+1
  task automatic single_op(input logic [3:0] av, input logic [3:0] bv, input logic p,
                           input logic [2:0] c, input logic [2:0] ij);
    drive(av, bv, p, c, ij);
    @(posedge clk); #1;
    in_valid = 1'b0; inj = 3'b000;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; par = 1'b0;
    ctl = 3'b001; inj = '0; clr_fail = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 8'(out_valid), 8'd0);
    chk("rst.sum",   8'(sum), 8'd0);
    chk("rst.err",   8'({err0, err1}), 8'b01);
    chk("rst.mode",  8'(mode), 8'd0);
    chk("rst.mask",  8'(fail_mask), 8'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    single_op(4'd5, 4'd6, 1'b1, 3'b001, 3'b000);
    chk_res("add5_6", 4'd11, 1'b0, 2'b01);
    chk("add5_6.mode", 8'(mode), 8'd0);

    single_op(4'd3, 4'd5, 1'b1, 3'b010, 3'b000);
    chk_res("sub3_5", 4'd14, 1'b0, 2'b01);
    @(posedge clk); #1;
    chk("hold.valid", 8'(out_valid), 8'd0);
    chk("hold.sum",   8'(sum), 8'd14);
    chk("hold.err",   8'({err0, err1}), 8'b01);

    single_op(4'd3, 4'd5, 1'b1, 3'b100, 3'b000);
    chk_res("rsub3_5", 4'd2, 1'b1, 2'b01);
    single_op(4'd9, 4'd8, 1'b0, 3'b001, 3'b000);
    chk_res("add9_8", 4'd1, 1'b1, 2'b01);
    single_op(4'd5, 4'd3, 1'b1, 3'b010, 3'b000);
    chk_res("sub5_3", 4'd2, 1'b1, 2'b01);

    single_op(4'd5, 4'd6, 1'b0, 3'b001, 3'b000);
    chk_res("par_err", 4'd0, 1'b0, 2'b00);
    single_op(4'd5, 4'd6, 1'b1, 3'b011, 3'b000);
    chk_res("ctl_err", 4'd0, 1'b0, 2'b00);

    // replica 1 faulty; an in_err op in between must not advance its counter
    single_op(4'd5, 4'd6, 1'b1, 3'b001, 3'b010);
    chk_res("inj1_a", 4'd11, 1'b0, 2'b01);
    single_op(4'd5, 4'd6, 1'b1, 3'b001, 3'b010);
    chk_res("inj1_b", 4'd11, 1'b0, 2'b01);
    chk("inj1_b.mask", 8'(fail_mask), 8'b000);
    single_op(4'd5, 4'd6, 1'b0, 3'b001, 3'b010);
    chk_res("inj1_parerr", 4'd0, 1'b0, 2'b00);
    chk("inj1_parerr.mask", 8'(fail_mask), 8'b000);
    single_op(4'd5, 4'd6, 1'b1, 3'b001, 3'b010);
    chk_res("inj1_c", 4'd11, 1'b0, 2'b01);
    chk("retire1.mask", 8'(fail_mask), 8'b010);
    chk("retire1.mode", 8'(mode), 8'd1);

    single_op(4'd5, 4'd6, 1'b1, 3'b001, 3'b001);
    chk_res("dmr_inj0", 4'd10, 1'b0, 2'b00);
    single_op(4'd5, 4'd6, 1'b1, 3'b001, 3'b010);
    chk_res("dmr_inj_retired", 4'd11, 1'b0, 2'b01);

    clr_fail = 1'b1;
    @(posedge clk); #1;
    clr_fail = 1'b0;
    chk("clr.mask", 8'(fail_mask), 8'b000);
    chk("clr.mode", 8'(mode), 8'd0);

    // clr_fail on the same edge as what would be the retiring increment
    single_op(4'd5, 4'd6, 1'b1, 3'b001, 3'b100);
    single_op(4'd5, 4'd6, 1'b1, 3'b001, 3'b100);
    drive(4'd5, 4'd6, 1'b1, 3'b001, 3'b100);
    @(posedge clk); #1;
    in_valid = 1'b0; inj = 3'b000; clr_fail = 1'b1;
    @(posedge clk); #1;
    clr_fail = 1'b0;
    chk_res("clr_race", 4'd11, 1'b0, 2'b01);
    chk("clr_race.mask", 8'(fail_mask), 8'b000);
    chk("clr_race.mode", 8'(mode), 8'd0);

    // leaky counter 2 -> 0 -> 2, then one more retires
    single_op(4'd5, 4'd6, 1'b1, 3'b001, 3'b100);
    single_op(4'd5, 4'd6, 1'b1, 3'b001, 3'b100);
    chk("leak_up.mask", 8'(fail_mask), 8'b000);
    single_op(4'd5, 4'd6, 1'b1, 3'b001, 3'b000);
    single_op(4'd5, 4'd6, 1'b1, 3'b001, 3'b000);
    single_op(4'd5, 4'd6, 1'b1, 3'b001, 3'b100);
    single_op(4'd5, 4'd6, 1'b1, 3'b001, 3'b100);
    chk("leak_again.mask", 8'(fail_mask), 8'b000);
    single_op(4'd5, 4'd6, 1'b1, 3'b001, 3'b100);
    chk("leak_retire.mask", 8'(fail_mask), 8'b100);
    chk("leak_retire.mode", 8'(mode), 8'd1);
    single_op(4'd5, 4'd6, 1'b1, 3'b001, 3'b001);
    chk_res("dmr2_inj0", 4'd10, 1'b0, 2'b00);
    clr_fail = 1'b1;
    @(posedge clk); #1;
    clr_fail = 1'b0;
    chk("clr2.mask", 8'(fail_mask), 8'b000);

    // back-to-back throughput
    drive(4'd1, 4'd2, 1'b1, 3'b001, 3'b000);
    @(posedge clk); #1;
    drive(4'd2, 4'd2, 1'b1, 3'b001, 3'b000);
    @(posedge clk); #1;
    chk_res("b2b_0", 4'd3, 1'b0, 2'b01);
    drive(4'd3, 4'd2, 1'b0, 3'b001, 3'b000);
    @(posedge clk); #1;
    chk_res("b2b_1", 4'd4, 1'b0, 2'b01);
    drive(4'd4, 4'd2, 1'b1, 3'b001, 3'b000);
    @(posedge clk); #1;
    chk_res("b2b_2", 4'd5, 1'b0, 2'b01);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk_res("b2b_3", 4'd6, 1'b0, 2'b01);
    @(posedge clk); #1;
    chk("b2b_end.valid", 8'(out_valid), 8'd0);

    // reset with an op sitting in stage 1
    single_op(4'd5, 4'd6, 1'b0, 3'b001, 3'b000);
    chk_res("pre_rst", 4'd0, 1'b0, 2'b00);
    drive(4'd5, 4'd6, 1'b1, 3'b001, 3'b000);
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst.valid", 8'(out_valid), 8'd0);
    chk("midrst.err",   8'({err0, err1}), 8'b01);
    chk("midrst.sum",   8'(sum), 8'd0);
    @(posedge clk); #1;
    chk("midrst_after.valid", 8'(out_valid), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
